interrupt_ack_sequencer: RTL and testbench
==========================================

# interrupt_ack_sequencer

Sequences the CPU interrupt-acknowledge (INTA) cycle of the 8259A. It synchronises the `inta_n` strobe and walks the shared control state (IDLE/ACK1/ACK2/ACK3) that the cascade logic decodes. It latches the acknowledged level, pulses in-service latching and end-of-acknowledge, and drives the vector/CALL bytes onto the data bus when the cascade logic permits. It sits between the bus interface, priority resolver, ISR and cascade-signal logic.

## Interface
Parameters:
- none; all encodings come from the package.

Ports (clock and reset first):
- `clock`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `inta_n`  in  1  CPU acknowledge strobe, asynchronous, active-low.
- `init_command`  in  1  ICW1 write pulse; aborts any sequence.
- `x86_mode`  in  1  1 = 8086 (2 INTA pulses); 0 = 8080 (3 pulses).
- `auto_eoi_config`  in  1  AEOI mode enabled.
- `call_interval_4`  in  1  8080 address interval: 1 = 4, 0 = 8.
- `vector_base`  in  8  ICW2 contents.
- `address_low`  in  3  ICW1 bits A7..A5 (8080 mode).
- `highest_request`  in  8  one-hot highest-priority unmasked request from the resolver.
- `cascade_output_ack_2_3`  in  1  from the cascade logic; permits driving the bus on ACK2/ACK3.
- `control_state`  out  2  current state (IDLE/ACK1/ACK2/ACK3).
- `acknowledge_interrupt`  out  8  one-hot level latched at the first INTA.
- `freeze`  out  1  holds the IRR/priority resolver during the sequence.
- `latch_in_service`  out  1  one-cycle pulse; sets the ISR bit.
- `end_of_acknowledge`  out  1  one-cycle pulse at the end of the final INTA.
- `auto_eoi_pulse`  out  1  one-cycle pulse with `end_of_acknowledge` when AEOI is enabled.
- `data_out`  out  8  byte for the data bus.
- `data_out_enable`  out  1  drive the data bus.

## Operation
- `inta_n` passes through a 2-flop synchroniser (reset value 1), then a registered edge detector producing `fall`/`rise` strobes.
- State transitions:
  - IDLE --`fall`--> ACK1. Same cycle: latch `acknowledge_interrupt` <= `highest_request`; pulse `latch_in_service`; set `freeze`.
  - ACK1 --`rise`--> ACK2.
  - ACK2 --`rise`--> IDLE if `x86_mode`=1, otherwise ACK3.
  - ACK3 --`rise`--> IDLE.
  - Every return to IDLE via `rise` pulses `end_of_acknowledge`, plus `auto_eoi_pulse` if `auto_eoi_config`=1, and clears `freeze`.
  - `fall` strobes outside IDLE only move the pulse phase. No other action.
- Level number L = binary encoding of `acknowledge_interrupt`. If `acknowledge_interrupt` is all-zero (spurious request), L = 7.
- Bytes driven while `inta_n` is low (synchronised):
  - 8086, ACK1: not driven.
  - 8086, ACK2: {`vector_base`[7:3], L}.
  - 8080, ACK1: 8'hCD.
  - 8080, ACK2, interval 4: {`address_low`, L, 2'b00}.
  - 8080, ACK2, interval 8: {`address_low`[2:1], L, 3'b000}.
  - 8080, ACK3: `vector_base`.
- Bus enable:
  - `data_out_enable` = synchronised `inta_n` low AND a byte is defined for the current phase.
  - On ACK2/ACK3, `cascade_output_ack_2_3` must also be 1.
  - 8080 ACK1 (CALL opcode) is driven only when `cascade_output_ack_2_3`=1.
- `data_out` is 0 whenever `data_out_enable`=0.
- `init_command` forces IDLE next cycle. It clears `freeze`, `acknowledge_interrupt` and the bus enable, and produces no `end_of_acknowledge`.
- Reset values: state IDLE; every output 0; synchroniser flops 1.
- Reset mid-sequence: all outputs drop asynchronously; no pulses are emitted afterwards; the first `fall` after release starts a fresh ACK1.

## Timing
- `inta_n` fall to `control_state`=ACK1 and the `latch_in_service` pulse: 3 rising edges (2 sync + 1 state register). The same latency applies to `rise`.
- `data_out`/`data_out_enable` are registered and valid in the same cycle the state update becomes visible. They deassert 3 edges after `inta_n` rises.
- Pulses (`latch_in_service`, `end_of_acknowledge`, `auto_eoi_pulse`) are exactly 1 cycle wide.
- `acknowledge_interrupt` is stable from ACK1 until the return to IDLE, and holds its value in IDLE until the next ACK1.
- INTA low and high phases must each last at least 2 clocks; shorter glitches are not required to be detected.
- Simultaneous `init_command` and `rise`: init wins; no `end_of_acknowledge`.

## Structure
- Shared package `pic8259_pkg`:
  - `control_state_t` encodings: CTL_IDLE=2'd0, CTL_ACK1=2'd1, CTL_ACK2=2'd2, CTL_ACK3=2'd3. The cascade-signal logic imports the same constants.
  - `CALL_OPCODE` = 8'hCD.
  - Function `bit2num` (one-hot to 3-bit, zero input maps to 7).
- Sub-module `inta_edge_sync`: synchroniser plus edge detector, outputs `inta_low`, `fall`, `rise`.
- FSM and byte mux stay in the top module.

## Test plan
- 8086, `vector_base`=8'h40, `highest_request`=8'b0000_1000, two INTA pulses:
  - ACK1: `latch_in_service` pulse, no bus drive.
  - ACK2: `data_out`=8'h43.
  - Then one `end_of_acknowledge` pulse and IDLE.
- 8080, interval 4, `address_low`=3'b101, IR5, `vector_base`=8'h12 -> bytes 8'hCD, 8'hB4, 8'h12 on three pulses; then IDLE.
- Spurious case: `highest_request`=0 at INTA1, 8086, `vector_base`=8'h40 -> `acknowledge_interrupt`=0, ACK2 byte 8'h47.
- `cascade_output_ack_2_3`=0 (cascaded master, slave-owned IR) -> state walks ACK1 -> ACK2 -> IDLE but `data_out_enable` stays 0.
- AEOI enabled -> `auto_eoi_pulse` coincides with `end_of_acknowledge`. AEOI disabled -> `auto_eoi_pulse` never asserts.
- Abort cases:
  - `reset_n` low during ACK2 -> outputs 0 immediately, no `end_of_acknowledge`.
  - `init_command` during ACK1 -> IDLE next cycle, `freeze`=0.

Source files
------------

// File: rtl/pic8259_pkg.sv
// Shared 8259A control-state encodings and helpers used by the INTA sequencer
// and the cascade-signal logic.
package pic8259_pkg;

    typedef enum logic [1:0] {
        CTL_IDLE = 2'd0,
        CTL_ACK1 = 2'd1,
        CTL_ACK2 = 2'd2,
        CTL_ACK3 = 2'd3
    } control_state_t;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    // One-hot level to its number; an empty vector is a spurious request and reports level 7.
    function automatic logic [2:0] bit2num(input logic [7:0] onehot);
        logic [2:0] num;
        num = 3'd7;
        for (int unsigned i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                num = 3'(i);
            end
        end
        return num;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_inta_edge_sync.sv
// Two-flop synchroniser for the asynchronous INTA strobe followed by a
// registered edge detector producing single-cycle fall/rise strobes.
module inta_edge_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic inta_n,
    output logic inta_low,
    output logic fall,
    output logic rise
);

    logic sync_meta;
    logic sync_inta_n;
    logic prev_inta_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta   <= 1'b1;
            sync_inta_n <= 1'b1;
            prev_inta_n <= 1'b1;
        end else begin
            sync_meta   <= inta_n;
            sync_inta_n <= sync_meta;
            prev_inta_n <= sync_inta_n;
        end
    end

    assign inta_low = ~sync_inta_n;
    assign fall     = prev_inta_n & ~sync_inta_n;
    assign rise     = ~prev_inta_n & sync_inta_n;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259A interrupt-acknowledge sequencer: walks IDLE/ACK1/ACK2/ACK3 on the
// synchronised INTA strobe and drives the CALL/vector bytes onto the bus.
module interrupt_ack_sequencer
    import pic8259_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       inta_n,
    input  logic       init_command,
    input  logic       x86_mode,
    input  logic       auto_eoi_config,
    input  logic       call_interval_4,
    input  logic [7:0] vector_base,
    input  logic [2:0] address_low,
    input  logic [7:0] highest_request,
    input  logic       cascade_output_ack_2_3,
    output logic [1:0] control_state,
    output logic [7:0] acknowledge_interrupt,
    output logic       freeze,
    output logic       latch_in_service,
    output logic       end_of_acknowledge,
    output logic       auto_eoi_pulse,
    output logic [7:0] data_out,
    output logic       data_out_enable
);

    logic inta_low;
    logic fall;
    logic rise;

    inta_edge_sync u_inta_edge_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .inta_n   (inta_n),
        .inta_low (inta_low),
        .fall     (fall),
        .rise     (rise)
    );

    control_state_t state;
    control_state_t state_next;
    logic [7:0]     ack_next;
    logic           enter_ack;
    logic           leave_ack;
    logic [2:0]     level;
    logic           byte_defined;
    logic [7:0]     byte_value;
    logic           drive;

    always_comb begin
        state_next = state;
        ack_next   = acknowledge_interrupt;
        enter_ack  = 1'b0;
        leave_ack  = 1'b0;
        if (init_command) begin
            state_next = CTL_IDLE;
            ack_next   = '0;
        end else begin
            case (state)
                CTL_IDLE: begin
                    if (fall) begin
                        state_next = CTL_ACK1;
                        ack_next   = highest_request;
                        enter_ack  = 1'b1;
                    end
                end
                CTL_ACK1: begin
                    if (rise) begin
                        state_next = CTL_ACK2;
                    end
                end
                CTL_ACK2: begin
                    if (rise) begin
                        state_next = x86_mode ? CTL_IDLE : CTL_ACK3;
                        leave_ack  = x86_mode;
                    end
                end
                default: begin
                    if (rise) begin
                        state_next = CTL_IDLE;
                        leave_ack  = 1'b1;
                    end
                end
            endcase
        end

        // Bus byte is chosen from the phase being entered so it appears with the state change.
        level        = bit2num(ack_next);
        byte_defined = 1'b0;
        byte_value   = '0;
        case (state_next)
            CTL_ACK1: begin
                if (!x86_mode) begin
                    byte_defined = 1'b1;
                    byte_value   = CALL_OPCODE;
                end
            end
            CTL_ACK2: begin
                byte_defined = 1'b1;
                if (x86_mode) begin
                    byte_value = {vector_base[7:3], level};
                end else if (call_interval_4) begin
                    byte_value = {address_low, level, 2'b00};
                end else begin
                    byte_value = {address_low[2:1], level, 3'b000};
                end
            end
            CTL_ACK3: begin
                byte_defined = 1'b1;
                byte_value   = vector_base;
            end
            default: begin
                byte_defined = 1'b0;
            end
        endcase

        drive = inta_low & byte_defined & cascade_output_ack_2_3;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= CTL_IDLE;
            acknowledge_interrupt <= '0;
            freeze                <= 1'b0;
            latch_in_service      <= 1'b0;
            end_of_acknowledge    <= 1'b0;
            auto_eoi_pulse        <= 1'b0;
            data_out              <= '0;
            data_out_enable       <= 1'b0;
        end else begin
            state                 <= state_next;
            acknowledge_interrupt <= ack_next;
            latch_in_service      <= enter_ack;
            end_of_acknowledge    <= leave_ack;
            auto_eoi_pulse        <= leave_ack & auto_eoi_config;
            data_out_enable       <= drive;
            data_out              <= drive ? byte_value : '0;
            if (init_command || leave_ack) begin
                freeze <= 1'b0;
            end else if (enter_ack) begin
                freeze <= 1'b1;
            end
        end
    end

    assign control_state = state;

    a_bus_quiet_when_disabled : assert property (
        @(posedge clock) disable iff (!reset_n) data_out_enable || (data_out == '0));

    a_aeoi_with_eoa : assert property (
        @(posedge clock) disable iff (!reset_n) !auto_eoi_pulse || end_of_acknowledge);

    a_pulses_exclusive : assert property (
        @(posedge clock) disable iff (!reset_n) !(latch_in_service && end_of_acknowledge));

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Randomised and directed bench for interrupt_ack_sequencer, checked every
// cycle against a phase-counting behavioural model of the INTA protocol.
module tb_interrupt_ack_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       inta_n = 1'b1;
    logic       init_command = 1'b0;
    logic       x86_mode = 1'b1;
    logic       auto_eoi_config = 1'b0;
    logic       call_interval_4 = 1'b0;
    logic [7:0] vector_base = 8'h00;
    logic [2:0] address_low = 3'd0;
    logic [7:0] highest_request = 8'h00;
    logic       cascade_output_ack_2_3 = 1'b1;
    logic [1:0] control_state;
    logic [7:0] acknowledge_interrupt;
    logic       freeze;
    logic       latch_in_service;
    logic       end_of_acknowledge;
    logic       auto_eoi_pulse;
    logic [7:0] data_out;
    logic       data_out_enable;

    interrupt_ack_sequencer dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .inta_n                 (inta_n),
        .init_command           (init_command),
        .x86_mode               (x86_mode),
        .auto_eoi_config        (auto_eoi_config),
        .call_interval_4        (call_interval_4),
        .vector_base            (vector_base),
        .address_low            (address_low),
        .highest_request        (highest_request),
        .cascade_output_ack_2_3 (cascade_output_ack_2_3),
        .control_state          (control_state),
        .acknowledge_interrupt  (acknowledge_interrupt),
        .freeze                 (freeze),
        .latch_in_service       (latch_in_service),
        .end_of_acknowledge     (end_of_acknowledge),
        .auto_eoi_pulse         (auto_eoi_pulse),
        .data_out               (data_out),
        .data_out_enable        (data_out_enable)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phase = number of INTA pulses begun in this sequence (0 = idle).
    // The DUT sees inta_n two edges late; h0/h1/h2 hold samples from 1/2/3 edges ago.
    int         m_phase;
    logic [7:0] m_ack;
    logic [7:0] m_dout;
    logic       m_freeze, m_lis, m_eoi, m_aeoi, m_en;
    logic       h0, h1, h2;

    function automatic int level_of(input logic [7:0] a);
        int l;
        l = 7;
        for (int i = 0; i < 8; i++) begin
            if (a == (8'd1 << i)) l = i;
        end
        return l;
    endfunction

    function automatic logic [8:0] expected_byte(input int phase, input logic [7:0] a);
        int l;
        int v;
        l = level_of(a);
        v = -1;
        if (x86_mode) begin
            if (phase == 2) v = int'(vector_base & 8'hF8) + l;
        end else begin
            case (phase)
                1: v = 'hCD;
                2: v = call_interval_4 ? int'(address_low) * 32 + l * 4
                                       : (int'(address_low) / 2) * 64 + l * 8;
                3: v = int'(vector_base);
                default: v = -1;
            endcase
        end
        return (v < 0) ? 9'h000 : {1'b1, 8'(v)};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0;
            m_ack = 8'h00;
            m_dout = 8'h00;
            m_freeze = 1'b0; m_lis = 1'b0; m_eoi = 1'b0; m_aeoi = 1'b0; m_en = 1'b0;
            h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
        end else begin : model_step
            logic seen_high;
            logic fall_seen;
            logic rise_seen;
            logic [8:0] eb;
            int pulses_needed;
            seen_high = h1;
            fall_seen = h2 && !h1;
            rise_seen = !h2 && h1;
            pulses_needed = x86_mode ? 2 : 3;
            m_lis = 1'b0; m_eoi = 1'b0; m_aeoi = 1'b0;
            if (init_command) begin
                m_phase = 0;
                m_ack = 8'h00;
                m_freeze = 1'b0;
            end else if (m_phase == 0) begin
                if (fall_seen) begin
                    m_phase = 1;
                    m_ack = highest_request;
                    m_lis = 1'b1;
                    m_freeze = 1'b1;
                end
            end else if (rise_seen) begin
                m_phase = m_phase + 1;
                if (m_phase > pulses_needed) begin
                    m_phase = 0;
                    m_eoi = 1'b1;
                    m_aeoi = auto_eoi_config;
                    m_freeze = 1'b0;
                end
            end
            eb = expected_byte(m_phase, m_ack);
            m_en = !init_command && !seen_high && (m_phase != 0) && cascade_output_ack_2_3 && eb[8];
            m_dout = m_en ? eb[7:0] : 8'h00;
            h2 = h1; h1 = h0; h0 = inta_n;
        end
    end

    bit         check_on = 1'b0;
    logic       prev_en = 1'b0;
    logic [7:0] cap[$];
    int         lis_count = 0, eoi_count = 0, aeoi_count = 0, aeoi_alone = 0, ack2_cycles = 0;

    always @(posedge clock) begin
        #1;
        if (reset_n && check_on) begin
            check("control_state", 32'(control_state), 32'(m_phase));
            check("acknowledge_interrupt", 32'(acknowledge_interrupt), 32'(m_ack));
            check("freeze", 32'(freeze), 32'(m_freeze));
            check("latch_in_service", 32'(latch_in_service), 32'(m_lis));
            check("end_of_acknowledge", 32'(end_of_acknowledge), 32'(m_eoi));
            check("auto_eoi_pulse", 32'(auto_eoi_pulse), 32'(m_aeoi));
            check("data_out_enable", 32'(data_out_enable), 32'(m_en));
            check("data_out", 32'(data_out), 32'(m_dout));
            if (data_out_enable && !prev_en) cap.push_back(data_out);
            if (latch_in_service) lis_count++;
            if (end_of_acknowledge) eoi_count++;
            if (auto_eoi_pulse) aeoi_count++;
            if (auto_eoi_pulse && !end_of_acknowledge) aeoi_alone++;
            if (control_state == 2'd2) ack2_cycles++;
            prev_en = data_out_enable;
        end else begin
            prev_en = 1'b0;
        end
    end

    function automatic logic [7:0] cap_at(input int i);
        return (i < cap.size()) ? cap[i] : 8'hxx;
    endfunction

    task automatic clear_stats();
        cap.delete();
        lis_count = 0; eoi_count = 0; aeoi_count = 0; aeoi_alone = 0; ack2_cycles = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(input int lo, input int hi);
        inta_n = 1'b0;
        cycles(lo);
        inta_n = 1'b1;
        cycles(hi);
    endtask

    task automatic random_tick(input bit allow_init);
        init_command = allow_init && ($urandom_range(0, 39) == 0);
        @(negedge clock);
        init_command = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        cycles(3);
        reset_n = 1'b1;
        @(negedge clock);
        check("reset control_state", 32'(control_state), 32'd0);
        check("reset data_out_enable", 32'(data_out_enable), 32'd0);
        check("reset acknowledge_interrupt", 32'(acknowledge_interrupt), 32'd0);
        check_on = 1'b1;

        // 8086, IR3, vector base 0x40
        clear_stats();
        x86_mode = 1'b1; vector_base = 8'h40; highest_request = 8'b0000_1000;
        cascade_output_ack_2_3 = 1'b1; auto_eoi_config = 1'b0;
        pulse(3, 3); pulse(3, 3); cycles(5);
        check("x86 byte count", 32'(cap.size()), 32'd1);
        check("x86 vector byte", 32'(cap_at(0)), 32'h43);
        check("x86 latch_in_service count", 32'(lis_count), 32'd1);
        check("x86 end_of_acknowledge count", 32'(eoi_count), 32'd1);
        check("aeoi off pulse count", 32'(aeoi_count), 32'd0);
        check("x86 final state", 32'(control_state), 32'd0);
        check("x86 acknowledged level", 32'(acknowledge_interrupt), 32'h08);

        // 8080, interval 4, A7..A5 = 101, IR5, AEOI on
        clear_stats();
        x86_mode = 1'b0; call_interval_4 = 1'b1; address_low = 3'b101;
        highest_request = 8'b0010_0000; vector_base = 8'h12; auto_eoi_config = 1'b1;
        pulse(3, 3); pulse(2, 3); pulse(4, 3); cycles(5);
        check("8080 byte count", 32'(cap.size()), 32'd3);
        check("8080 CALL byte", 32'(cap_at(0)), 32'hCD);
        check("8080 address byte", 32'(cap_at(1)), 32'hB4);
        check("8080 upper byte", 32'(cap_at(2)), 32'h12);
        check("8080 end_of_acknowledge count", 32'(eoi_count), 32'd1);
        check("aeoi pulse count", 32'(aeoi_count), 32'd1);
        check("aeoi without eoa", 32'(aeoi_alone), 32'd0);
        check("8080 final state", 32'(control_state), 32'd0);

        // Spurious request
        clear_stats();
        x86_mode = 1'b1; vector_base = 8'h40; highest_request = 8'h00; auto_eoi_config = 1'b0;
        pulse(3, 3); pulse(3, 3); cycles(5);
        check("spurious level", 32'(acknowledge_interrupt), 32'h00);
        check("spurious vector byte", 32'(cap_at(0)), 32'h47);

        // Cascade logic withholds the bus
        clear_stats();
        highest_request = 8'b1000_0000; cascade_output_ack_2_3 = 1'b0;
        pulse(3, 3); pulse(3, 3); cycles(5);
        check("no-cascade byte count", 32'(cap.size()), 32'd0);
        check("no-cascade visited ACK2", 32'(ack2_cycles > 0), 32'd1);
        check("no-cascade end_of_acknowledge", 32'(eoi_count), 32'd1);
        cascade_output_ack_2_3 = 1'b1;

        // Reset during ACK2 while driving
        clear_stats();
        highest_request = 8'b0000_1000;
        pulse(3, 3);
        inta_n = 1'b0;
        cycles(4);
        check("pre-reset state ACK2", 32'(control_state), 32'd2);
        check("pre-reset bus driven", 32'(data_out_enable), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async reset state", 32'(control_state), 32'd0);
        check("async reset data_out", 32'(data_out), 32'd0);
        check("async reset data_out_enable", 32'(data_out_enable), 32'd0);
        check("async reset freeze", 32'(freeze), 32'd0);
        check("async reset level", 32'(acknowledge_interrupt), 32'd0);
        @(negedge clock);
        inta_n = 1'b1;
        cycles(2);
        reset_n = 1'b1;
        cycles(6);
        check("post-reset end_of_acknowledge", 32'(eoi_count), 32'd0);
        clear_stats();
        pulse(3, 3); pulse(3, 3); cycles(5);
        check("post-reset fresh vector", 32'(cap_at(0)), 32'h43);
        check("post-reset fresh eoa", 32'(eoi_count), 32'd1);

        // init_command during ACK1
        clear_stats();
        inta_n = 1'b0;
        cycles(4);
        check("pre-init freeze", 32'(freeze), 32'd1);
        init_command = 1'b1;
        @(negedge clock);
        init_command = 1'b0;
        check("init state", 32'(control_state), 32'd0);
        check("init freeze", 32'(freeze), 32'd0);
        inta_n = 1'b1;
        cycles(6);
        check("init no eoa", 32'(eoi_count), 32'd0);
        check("init stays idle", 32'(control_state), 32'd0);

        // Randomised transactions
        for (int t = 0; t < 60; t++) begin
            int r;
            int npulses;
            x86_mode = 1'($urandom_range(0, 1));
            auto_eoi_config = 1'($urandom_range(0, 1));
            call_interval_4 = 1'($urandom_range(0, 1));
            vector_base = 8'($urandom);
            address_low = 3'($urandom);
            cascade_output_ack_2_3 = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 8);
            highest_request = (r == 8) ? 8'h00 : (8'd1 << r);
            init_command = 1'b1;
            @(negedge clock);
            init_command = 1'b0;
            npulses = (x86_mode ? 2 : 3) + $urandom_range(0, 4) / 3 - $urandom_range(0, 4) / 4;
            for (int p = 0; p < npulses; p++) begin
                int lo;
                int hi;
                lo = $urandom_range(2, 5);
                hi = $urandom_range(2, 5);
                inta_n = 1'b0;
                for (int c = 0; c < lo; c++) random_tick(1'b1);
                inta_n = 1'b1;
                for (int c = 0; c < hi; c++) random_tick(1'b1);
            end
            cycles($urandom_range(3, 6));
        end

        check_on = 1'b0;
        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
